// File: rtl/sync_fifo_pkg.sv
// Shared width/depth defaults for sync_fifo and the write arbiter in front of it,
// plus a small sizing helper used for index widths.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_NUM_REQ    = 4;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/consumer-facing bundle of the FIFO write arbiter: request side,
// FIFO write port and the status outputs.
interface fifo_wr_arbiter_if
  import sync_fifo_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int SRC_WIDTH = clog2_min1(NUM_REQ)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_rd_en;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic [SRC_WIDTH-1:0]          fifo_wr_src;
  logic [ADDR_WIDTH:0]           level;
  logic                          full;
  logic                          empty;
  logic                          underflow_err;

  // Producers and the consumer read strobe.
  modport master (
    output req_valid, req_data, fifo_rd_en,
    input  req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_src,
           level, full, empty, underflow_err
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_data, fifo_rd_en,
    output req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_src,
           level, full, empty, underflow_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Generic combinational round-robin arbiter: first request after last_grant,
// wrapping modulo N. The pointer register is owned by the caller.
module rr_arbiter
  import sync_fifo_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // One extra bit so last_grant + N never wraps before the modulo correction.
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    if (en) begin
      for (int k = 1; k <= N; k++) begin
        sum = {1'b0, last_grant} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(N)) begin
          sum = sum - (IDX_W+1)'(N);
        end
        cand = sum[IDX_W-1:0];
        if (!any && req[cand]) begin
          any       = 1'b1;
          gnt[cand] = 1'b1;
          idx       = cand;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one sync_fifo write port between NUM_REQ
// producers; tracks occupancy itself so the FIFO can never be overrun.
module fifo_wr_arbiter
  import sync_fifo_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int SRC_WIDTH = clog2_min1(NUM_REQ)
) (
  input  logic           clk,
  input  logic           rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int LEVEL_W = ADDR_WIDTH + 1;

  logic [LEVEL_W-1:0]    level_reg;
  logic [LEVEL_W-1:0]    level_next;
  logic                  wr_en_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;
  logic [SRC_WIDTH-1:0]  wr_src_reg;
  logic [SRC_WIDTH-1:0]  last_grant_reg;
  logic                  underflow_reg;

  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
  logic [NUM_REQ-1:0]    gnt;
  logic [SRC_WIDTH-1:0]  win_idx;
  logic                  win_any;
  logic                  space;
  logic                  acc;
  logic [LEVEL_W-1:0]    stored;
  logic                  rd_ok;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_word[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Space decision uses the registered level only, so a same-cycle read never
  // opens a slot early.
  assign space = (level_reg < LEVEL_W'(FIFO_DEPTH));

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req        (bus.req_valid),
    .last_grant (last_grant_reg),
    .en         (space),
    .gnt        (gnt),
    .idx        (win_idx),
    .any        (win_any)
  );

  assign bus.req_ready = gnt;
  assign acc           = |(bus.req_valid & gnt);

  // The word sitting in the output register is counted in level but is not yet
  // readable from the FIFO.
  assign stored = level_reg - LEVEL_W'(wr_en_reg);
  assign rd_ok  = bus.fifo_rd_en && (stored != '0);

  assign level_next = level_reg + LEVEL_W'(acc) - LEVEL_W'(rd_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg      <= '0;
      wr_en_reg      <= 1'b0;
      wr_data_reg    <= '0;
      wr_src_reg     <= '0;
      last_grant_reg <= SRC_WIDTH'(NUM_REQ - 1);
      underflow_reg  <= 1'b0;
    end else begin
      level_reg <= level_next;
      wr_en_reg <= acc;
      if (acc) begin
        wr_data_reg    <= req_word[win_idx];
        wr_src_reg     <= win_idx;
        last_grant_reg <= win_idx;
      end
      if (bus.fifo_rd_en && (stored == '0)) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign bus.fifo_wr_en    = wr_en_reg;
  assign bus.fifo_wr_data  = wr_data_reg;
  assign bus.fifo_wr_src   = wr_src_reg;
  assign bus.level         = level_reg;
  assign bus.full          = (level_reg == LEVEL_W'(FIFO_DEPTH));
  assign bus.empty         = (stored == '0);
  assign bus.underflow_err = underflow_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised scoreboard bench for fifo_wr_arbiter: a queue/counter model predicts
// grants and status, a separate monitor checks every FIFO write against it.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int data;
    int src;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: words in flight, pending-write flag, rotation pointer, sticky error.
  int   m_level;
  int   m_wr_en;
  int   m_last;
  int   m_uflow;
  logic [DW-1:0] pdata [N];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_winner();
    int c;
    if (m_level >= DEPTH) return -1;
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (bus.req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_level = 0;
    m_wr_en = 0;
    m_last  = N - 1;
    m_uflow = 0;
  endtask

  // Idle producers in mask get a fresh word; waiting producers keep theirs.
  task automatic refill(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i] && !bus.req_valid[i]) begin
        bus.req_valid[i] = 1'b1;
        pdata[i]         = DW'($urandom);
      end
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_level"}, int'(bus.level), m_level);
    check({tag, "_full"}, int'(bus.full), (m_level == DEPTH) ? 1 : 0);
    check({tag, "_empty"}, int'(bus.empty), (m_level - m_wr_en == 0) ? 1 : 0);
    check({tag, "_underflow"}, int'(bus.underflow_err), m_uflow);
    check({tag, "_wr_en"}, int'(bus.fifo_wr_en), m_wr_en);
  endtask

  // One clock: apply inputs, check the grant, advance the model, check status.
  task automatic step(input logic rd, input logic r);
    int w;
    int stored;
    int rd_ok;
    rst            = r;
    bus.fifo_rd_en = rd;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = pdata[i];
    #1;
    w = model_winner();
    check("req_ready", int'(bus.req_ready), (w < 0) ? 0 : (1 << w));
    if (!r && w >= 0) exp_q.push_back('{int'(pdata[w]), w});
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      stored = m_level - m_wr_en;
      rd_ok  = (rd && stored > 0) ? 1 : 0;
      if (rd && stored == 0) m_uflow = 1;
      m_level = m_level + ((w >= 0) ? 1 : 0) - rd_ok;
      m_wr_en = (w >= 0) ? 1 : 0;
      if (w >= 0) begin
        m_last           = w;
        bus.req_valid[w] = 1'b0;
      end
    end
    check_status("status");
  endtask

  // Monitor: every FIFO write must match the oldest accepted word.
  always @(negedge clk) begin
    if (bus.fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got data %0d src %0d expected no write",
                 bus.fifo_wr_data, bus.fifo_wr_src);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_data", int'(bus.fifo_wr_data), e.data);
        check("wr_src", int'(bus.fifo_wr_src), e.src);
      end
    end
  end

  initial begin
    int guard;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.fifo_rd_en = 1'b0;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_req_ready", int'(bus.req_ready), 0);
    check("reset_wr_data", int'(bus.fifo_wr_data), 0);
    check("reset_wr_src", int'(bus.fifo_wr_src), 0);
    check_status("reset");

    // Read at reset state: underflow, level untouched, cleared only by reset.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Single producer 0 with 0x11.
    bus.req_valid[0] = 1'b1;
    pdata[0]         = 8'h11;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // All valid, reading whenever something is stored.
    step(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      refill('1);
      step((m_level - m_wr_en) > 0, 1'b0);
    end

    // All valid, no reads: fills to DEPTH, then one read, then read+grant at full.
    step(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      refill('1);
      step(1'b0, 1'b0);
    end
    refill('1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      refill('1);
      step(1'b1, 1'b0);
    end

    // Read at level 1 while the only word is still pending (stored == 0).
    step(1'b0, 1'b1);
    bus.req_valid = '0;
    refill(4'b0100);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Reset while a write is pending at level 5; next grant goes to requester 0.
    step(1'b0, 1'b1);
    guard = 0;
    while (!(m_level == 5 && m_wr_en == 1) && guard < 20) begin
      refill('1);
      step(1'b0, 1'b0);
      guard++;
    end
    check("reach_level5", m_level, 5);
    refill('1);
    step(1'b0, 1'b1);
    refill('1);
    step(1'b0, 1'b0);
    check("post_reset_src", int'(bus.fifo_wr_src), 0);

    // Randomised traffic with occasional resets.
    step(1'b0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      refill(N'($urandom));
      step($urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    end

    // Drain: let the last pending write reach the monitor.
    bus.req_valid = '0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
